seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It generalises the single-bit half/full adder cells into a WIDTH-bit datapath. The datapath processes CHUNK bits per clock through one shared CHUNK-bit full-adder slice, with the carry held in a register between chunks. It is used where a wide add must fit small area and a start/done handshake to the surrounding control FSM is acceptable.

---
 rtl/seq_chunk_adder.sv | 164 ++++++++++++++++
 tb/tb_seq_chunk_adder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
// Multi-cycle WIDTH-bit adder/subtractor. It has one CHUNK-bit full-adder slice.
// The slice processes one chunk per clock, from the least significant chunk up.
// A register carries the carry from one chunk to the next.
//
// Optional feature macro: SUB_MODE_EN
//   defined   : sub=1 at start computes a-b as a + ~b + 1 (cin is ignored)
//   undefined : sub is ignored and the block always computes a + b + cin
//
// Handshake (start/done):
//   start is sampled on a rising edge only while the block is IDLE or DONE.
//   A sampled start captures a, b, cin and sub, and the block enters RUN for NCHUNK cycles.
//   busy is high during these cycles. Any start seen during RUN is dropped.
//   done then pulses for exactly one cycle. sum/cout/ovf change only on that
//   edge and hold until the next done.
//   A start seen in the DONE cycle is accepted, so operations can run back to back.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;

    // Operand B and carry-in as they are captured on an accepted start
    logic [WIDTH-1:0] b_cap;
    logic             c_cap;

`ifdef SUB_MODE_EN
    // Subtraction is two's complement: invert B and force the carry-in to 1
    assign b_cap = sub ? ~b : b;
    assign c_cap = sub ? 1'b1 : cin;
`else
    // The block only adds, so there is no inverter or mux on B
    logic unused_sub;
    assign unused_sub = sub;
    assign b_cap = b;
    assign c_cap = cin;
`endif

    // Signals for the shared slice and the partial result after this chunk
    int               base;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice_res;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic             msb_cin;
    logic             last;
    logic [WIDTH-1:0] next_part;

    // One CHUNK-bit full-adder slice acts on the chunk that idx_q selects
    always_comb begin
        base      = int'(idx_q) * CHUNK;
        a_sl      = a_q[base +: CHUNK];
        b_sl      = b_q[base +: CHUNK];
        slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        slice_s   = slice_res[CHUNK-1:0];
        slice_c   = slice_res[CHUNK];
        // Carry into the slice MSB: this is the carry into bit WIDTH-1 on the last chunk
        msb_cin   = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_s[CHUNK-1];
        last      = (idx_q == LAST_IDX);
        next_part = part_q;
        next_part[base +: CHUNK] = slice_s;
    end

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_cap;
                        carry_q <= c_cap;
                        part_q  <= '0;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    part_q  <= next_part;
                    carry_q <= slice_c;
                    if (last) begin
                        // The index returns to 0 so that it never selects beyond the operands
                        idx_q <= '0;
                        sum   <= next_part;
                        cout  <= slice_c;
                        ovf   <= msb_cin ^ slice_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_cap;
                        carry_q <= c_cap;
                        part_q  <= '0;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder.
// The bench has two instances: an 8-bit/2-bit-chunk instance, checked against the
// arithmetic model on every cycle, and a 4-bit/1-bit-chunk instance that is swept exhaustively.
module tb_seq_chunk_adder;

  localparam int W    = 8;
  localparam int C    = 2;
  localparam int NCH  = W / C;
  localparam int W4   = 4;
  localparam int NCH4 = 4;

`ifdef SUB_MODE_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  logic          start4 = 1'b0;
  logic [W4-1:0] a4     = '0;
  logic [W4-1:0] b4     = '0;
  logic          cin4   = 1'b0;
  logic          sub4   = 1'b0;
  logic          busy4, done4, cout4, ovf4;
  logic [W4-1:0] sum4;
  logic [1:0]    dbg_state4;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .dbg_state(dbg_state)
  );

  seq_chunk_adder #(.WIDTH(W4), .CHUNK(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .dbg_state(dbg_state4)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for a w-bit operation. It returns {ovf, cout, sum[31:0]}.
  // ovf is taken from the signed-range rule, not from the carry.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic s);
    longint mask, ux, uy, tot, sx, sy, st, ce;
    logic   ov, co;
    mask = (longint'(1) << w) - 1;
    ux   = longint'(x) & mask;
    uy   = (s && SUB_EN) ? (~longint'(y)) & mask : longint'(y) & mask;
    ce   = (s && SUB_EN) ? 1 : longint'(ci);
    tot  = ux + uy + ce;
    co   = ((tot >> w) & 1) != 0;
    sx   = (ux >= (longint'(1) << (w - 1))) ? ux - (longint'(1) << w) : ux;
    sy   = (uy >= (longint'(1) << (w - 1))) ? uy - (longint'(1) << w) : uy;
    st   = sx + sy + ce;
    ov   = (st > (longint'(1) << (w - 1)) - 1) || (st < -(longint'(1) << (w - 1)));
    return {ov, co, 32'(tot & mask)};
  endfunction

  // ---------------- behavioural model / scoreboard (8-bit instance) ----------------
  // An accepted operation produces its result NCH cycles later and is queued until then.
  logic [W+1:0] exp_q[$];
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W+1:0] m_res  = '0;

  initial begin
    logic [33:0] r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0;
        m_done = 1'b0;
        m_res  = '0;
        exp_q.delete();
      end else if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
        if (m_left == 0) m_res = exp_q.pop_front();
      end else begin
        m_done = 1'b0;
        if (start) begin
          r = ref_op(W, 32'(a), 32'(b), cin, sub);
          exp_q.push_back({r[33], r[32], r[W-1:0]});
          m_left = NCH;
        end
      end
    end
  end

  // Compare process: the outputs are checked against the model on every cycle
  initial begin
    forever begin
      @(negedge clk);
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      check("result", {ovf, cout, sum}, m_res);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("wait_idle_timeout", t < 20, 1'b1);
  endtask

  // Runs one operation and checks the latency, the busy length and a hand-computed result
  task automatic op8(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                     input logic [W+1:0] exp, input string name);
    int t, busy_cnt;
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y; cin = ci; sub = s;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    t = 0; busy_cnt = 0;
    while (!done && t < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1; t++;
    end
    check({name, "_latency"}, t, NCH);
    check({name, "_busy_cycles"}, busy_cnt, NCH);
    check({name, "_busy_at_done"}, busy, 1'b0);
    check({name, "_dut"}, {ovf, cout, sum}, exp);
    check({name, "_model"}, m_res, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_done, cyc, last_cyc, t;
    logic [33:0] r;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", {ovf, cout, sum}, 10'h0);
    check("reset_busy4", busy4, 1'b0);
    rst_n = 1'b1;

    // basic add: latency and result
    op8(8'h3C, 8'h0F, 1'b0, 1'b0, {2'b00, 8'h4B}, "add_3c_0f");
    // carry-out and signed overflow corners
    op8(8'hFF, 8'h01, 1'b1, 1'b0, {2'b01, 8'h01}, "add_ff_01_c1");
    op8(8'h7F, 8'h01, 1'b0, 1'b0, {2'b10, 8'h80}, "add_7f_01");
    op8(8'h00, 8'h00, 1'b0, 1'b0, {2'b00, 8'h00}, "add_zero");
    op8(8'h80, 8'h80, 1'b0, 1'b0, {2'b11, 8'h00}, "add_80_80");

`ifdef SUB_MODE_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1, {2'b00, 8'hFE}, "sub_05_07");
    op8(8'h80, 8'h01, 1'b0, 1'b1, {2'b11, 8'h7F}, "sub_80_01");
`else
    // sub has no effect when subtraction is not built in
    op8(8'h05, 8'h07, 1'b0, 1'b1, {2'b00, 8'h0C}, "sub_ignored");
`endif

    // start held high: three operations run back to back with new operands on every cycle
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    n_done = 0; cyc = 0; last_cyc = 0;
    while (n_done < 3 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done) begin
        if (n_done > 0) check("b2b_spacing", cyc - last_cyc, NCH + 1);
        last_cyc = cyc;
        n_done++;
        if (n_done == 3) start = 1'b0;
      end else begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
    end
    check("b2b_count", n_done, 3);

    // random traffic: start toggles freely, including during RUN
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    end
    start = 1'b0;
    wait_idle();

    // reset during RUN aborts the operation
    op8(8'h3C, 8'h0F, 1'b0, 1'b0, {2'b00, 8'h4B}, "pre_reset");
    @(posedge clk); #1;
    start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_sum", sum, 8'h00);
    check("rst_mid_cout", cout, 1'b0);
    check("rst_mid_ovf", ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", done, 1'b0);
    end
    op8(8'h3C, 8'h0F, 1'b0, 1'b0, {2'b00, 8'h4B}, "post_reset");

    // exhaustive sweep of the 4-bit, 1-bit-chunk instance
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vec;
      vec = 9'(v);
      @(posedge clk); #1;
      start4 = 1'b1; {a4, b4, cin4} = vec;
      @(posedge clk); #1;
      start4 = 1'b0;
      t = 0;
      while (!done4 && t < 12) begin
        @(posedge clk); #1; t++;
      end
      check("w4_latency", t, NCH4);
      r = ref_op(W4, 32'(vec[8:5]), 32'(vec[4:1]), vec[0], 1'b0);
      check("w4_result", {ovf4, cout4, sum4}, {r[33], r[32], r[3:0]});
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
